// File: rtl/neo_reset_seq.sv
// NeoGeo system reset sequencer: merges power-on, button and watchdog
// resets into one 68k/Z80 reset sequence with an nRESETP pulse.
module neo_reset_seq #(
    parameter int HOLD_CYCLES = 256,
    parameter int Z80_DELAY   = 64,
    parameter int WDOG_FRAMES = 8
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       CLK_EN_24_N,
    input  logic       BTN_RESET,
    input  logic       VBL,
    input  logic       WDOG_KICK,
    input  logic       WDOG_EN,
    output logic       nRESET_68K,
    output logic       nRESET_Z80,
    output logic       nRESETP,
    output logic [1:0] RST_CAUSE,
    output logic       WDOG_FIRED
);

    localparam int MAXC = (HOLD_CYCLES > Z80_DELAY) ? HOLD_CYCLES : Z80_DELAY;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] Z80_LAST  = CW'((Z80_DELAY > 0) ? Z80_DELAY - 1 : 0);
    localparam logic [3:0]    FC_LAST   = 4'(WDOG_FRAMES - 1);

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_Z80  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [1:0] C_POR  = 2'd0;
    localparam logic [1:0] C_BTN  = 2'd1;
    localparam logic [1:0] C_WDOG = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    fc;
    logic          kick_pend;
    logic          vbl_pend;
    logic          vbl_q;

    logic kick;
    logic vbl;
    logic wd_on;
    logic fire;

    // Events seen this cycle are merged with the pending ones so a kick
    // or VBL edge landing on the tick edge itself is not dropped.
    always_comb begin
        kick  = kick_pend | WDOG_KICK;
        vbl   = vbl_pend | (VBL & ~vbl_q);
        wd_on = (state == S_RUN) && WDOG_EN;
        fire  = wd_on && !kick && vbl && (fc == FC_LAST);
    end

    // Capture kick and VBL rising edge between enable ticks.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            vbl_q     <= 1'b0;
            kick_pend <= 1'b0;
            vbl_pend  <= 1'b0;
        end else begin
            vbl_q <= VBL;
            if (CLK_EN_24_N) begin
                kick_pend <= 1'b0;
                vbl_pend  <= 1'b0;
            end else begin
                kick_pend <= kick;
                vbl_pend  <= vbl;
            end
        end
    end

    // Reset sequencing FSM with button and watchdog overrides.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state      <= S_HOLD;
            cnt        <= '0;
            nRESET_68K <= 1'b0;
            nRESET_Z80 <= 1'b0;
            nRESETP    <= 1'b1;
            RST_CAUSE  <= C_POR;
        end else if (CLK_EN_24_N) begin
            nRESETP <= 1'b1;
            if (BTN_RESET || fire) begin
                state      <= S_HOLD;
                cnt        <= '0;
                nRESET_68K <= 1'b0;
                nRESET_Z80 <= 1'b0;
                RST_CAUSE  <= BTN_RESET ? C_BTN : C_WDOG;
            end else begin
                case (state)
                    S_HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            cnt        <= '0;
                            nRESETP    <= 1'b0;
                            nRESET_68K <= 1'b1;
                            if (Z80_DELAY == 0) begin
                                state      <= S_RUN;
                                nRESET_Z80 <= 1'b1;
                            end else begin
                                state <= S_Z80;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_Z80: begin
                        if (cnt == Z80_LAST) begin
                            cnt        <= '0;
                            state      <= S_RUN;
                            nRESET_Z80 <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_RUN: begin
                        cnt <= '0;
                    end
                    default: begin
                        state <= S_HOLD;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Watchdog frame counter and sticky fired flag.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            fc         <= 4'd0;
            WDOG_FIRED <= 1'b0;
        end else if (CLK_EN_24_N) begin
            if (BTN_RESET || fire || !wd_on || kick) begin
                fc <= 4'd0;
            end else if (vbl) begin
                fc <= fc + 4'd1;
            end
            if (!BTN_RESET && fire) begin
                WDOG_FIRED <= 1'b1;
            end else if ((state == S_RUN) && kick) begin
                WDOG_FIRED <= 1'b0;
            end
        end
    end

endmodule

// File: doc/neo_reset_seq.md
# neo_reset_seq

System reset sequencer for the NeoGeo core: it merges power-on reset, the user reset button and the 68k watchdog into one reset sequence. It drives the 68k and Z80 reset lines with a fixed hold time and a staggered Z80 release, and emits the one-tick nRESETP pulse consumed by the video/IO chips. All sequencing advances on the 24 MHz enable tick.

## Interface
Parameters:
- HOLD_CYCLES, 256: enable ticks both CPUs stay in reset (≥1)
- Z80_DELAY, 64: enable ticks between 68k release and Z80 release (0 allowed)
- WDOG_FRAMES, 8: VBL rising edges without a kick before the watchdog fires (1..15)

Ports:
- CLK  in  1  system clock. One clock; reset is asynchronous and active-low.
- nRESET  in  1  asynchronous active-low reset (power-on)
- CLK_EN_24_N  in  1  sequencing enable tick
- BTN_RESET  in  1  user reset request, level, synchronous to CLK
- VBL  in  1  vertical blank level, synchronous to CLK
- WDOG_KICK  in  1  one-CLK strobe on 68k watchdog write
- WDOG_EN  in  1  1 = watchdog armed
- nRESET_68K  out  1  68k reset, low = held
- nRESET_Z80  out  1  Z80 reset, low = held
- nRESETP  out  1  low for exactly one enable tick at 68k release
- RST_CAUSE  out  2  last reset cause: 0 = power-on, 1 = button, 2 = watchdog
- WDOG_FIRED  out  1  sticky; set on watchdog reset, cleared by the first kick after release

## Operation
- Sticky capture flags, updated every CLK:
  - kick_pend is set by WDOG_KICK.
  - vbl_pend is set on a VBL 0→1 edge (edge detector uses a registered copy of VBL).
  - Both flags are consumed, and cleared, on the next enable tick.
- All other state updates only on CLK edges with CLK_EN_24_N = 1.
- States:
  - S_HOLD: both resets low. cnt increments. At cnt = HOLD_CYCLES-1, go to S_Z80 (or S_RUN if Z80_DELAY = 0) and clear cnt.
  - S_Z80: 68k released, Z80 held. At cnt = Z80_DELAY-1, go to S_RUN.
  - S_RUN: both released; watchdog active.
- BTN_RESET = 1 on a tick, in any state:
  - go to S_HOLD, clear cnt, set RST_CAUSE = 1.
  - While the button stays high, cnt stays at 0, so the hold time counts from button release.
- Watchdog, in S_RUN with WDOG_EN = 1:
  - kick_pend clears frame counter fc to 0.
  - Otherwise vbl_pend increments fc.
  - A vbl_pend with fc = WDOG_FRAMES-1 and no kick fires the watchdog: go to S_HOLD, RST_CAUSE = 2, WDOG_FIRED = 1, fc = 0.
- fc is held at 0 outside S_RUN or when WDOG_EN = 0.
- Priority on one tick: button > watchdog fire > normal sequencing; kick > VBL.
- nRESETP goes 0 on the tick leaving S_HOLD and returns to 1 on the next tick.
- cnt width is clog2(max(HOLD_CYCLES, Z80_DELAY)+1); fc is 4 bits.

## Timing
- Async reset values:
  - state S_HOLD, cnt 0, fc 0, both pend flags 0
  - nRESET_68K 0, nRESET_Z80 0, nRESETP 1
  - RST_CAUSE 0, WDOG_FIRED 0
- After nRESET deasserts:
  - nRESET_68K rises on enable tick HOLD_CYCLES, i.e. the HOLD_CYCLES-th enable edge.
  - nRESETP is low during that same tick.
  - nRESET_Z80 rises Z80_DELAY ticks later; with Z80_DELAY = 0 it rises on the same tick as nRESET_68K.
- All outputs are registered; no combinational path from any input.
- nRESET asserted mid-sequence returns everything to reset values immediately. RST_CAUSE becomes 0 even if it was button or watchdog.
- A watchdog fire asserts both resets on the firing tick.
- A kick arriving between enable ticks is never lost.
- A VBL pulse shorter than one enable period is still counted once.

## Test plan
- Power-on, HOLD_CYCLES = 4, Z80_DELAY = 2, enable every 4th CLK:
  - nRESET_68K rises on enable tick 4.
  - nRESETP is low for that tick only.
  - nRESET_Z80 rises on tick 6.
  - RST_CAUSE = 0.
- Button held for 10 ticks during S_RUN:
  - Both resets go low on the next tick.
  - 68k is released 4 ticks after the button falls.
  - RST_CAUSE = 1; WDOG_FIRED = 0.
- WDOG_EN = 1, WDOG_FRAMES = 3, no kicks:
  - Reset asserts on the 3rd VBL edge after entering S_RUN.
  - RST_CAUSE = 2; WDOG_FIRED = 1.
  - The first kick after the Z80 release clears WDOG_FIRED.
- Kick and VBL edge in the same enable period with fc = 2, WDOG_FRAMES = 3: no fire, fc = 0.
- Button and watchdog fire on the same tick: RST_CAUSE = 1, WDOG_FIRED = 0.
- nRESET pulsed low during S_Z80:
  - All outputs return to reset values immediately.
  - The full HOLD_CYCLES sequence restarts.
- Z80_DELAY = 0: both resets rise on the same tick as the nRESETP pulse.
